pc_branch_ctrl: RTL and testbench
=================================

PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 Parameter n, default 32: width of PC, immediate and target paths.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter FLUSH_CYCLES, default 2, legal range 1..7: number of cycles flush is held after a redirect.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 nReset  input  1  reset, synchronous and active-low.
REQ-006 stall  input  1  hold request from the pipeline.
REQ-007 branch  input  1  a conditional branch is in execute.
REQ-008 jump  input  1  jal/jalr in execute; always taken.
REQ-009 funct3  input  3  branch condition code.
REQ-010 flags  input  2  comparator result: [0] A==B, [1] A>=B (signed or unsigned as selected upstream).
REQ-011 branch_pc  input  n  PC of the instruction in execute.
REQ-012 imm  input  n  sign-extended branch offset.
REQ-013 jump_target  input  n  absolute jump destination.
REQ-014 pc  output  n  current fetch PC.
REQ-015 taken  output  1  one-cycle pulse: redirect occurred.
REQ-016 flush  output  1  kill the younger in-flight instructions.
REQ-017 illegal  output  1  one-cycle pulse: reserved funct3 seen.
REQ-018 misalign  output  1  one-cycle pulse: target[1:0] != 0.

Function
REQ-019 Condition decode SHALL be: 000 taken if flags[0]; 001 taken if !flags[0]; 100/110 taken if !flags[1]; 101/111 taken if flags[1]; 010/011 reserved, never taken.
REQ-020 Branch target SHALL be branch_pc + imm, modulo 2^n; jump target SHALL be jump_target; jump SHALL take priority over branch.
REQ-021 The FSM SHALL have states RUN and FLUSH.
REQ-022 Inputs branch and jump SHALL be acted on only in RUN with stall low; otherwise they SHALL be ignored.
REQ-023 In RUN, when an accepted transfer is taken and the target is aligned: pc <= target, taken pulses on the next cycle, the state changes to FLUSH, and the counter loads FLUSH_CYCLES.
REQ-024 When no transfer is taken, pc <= pc + 4 when stall is low; pc SHALL hold when stall is high.
REQ-025 flush SHALL be high exactly while in FLUSH.
REQ-026 In FLUSH, each non-stalled cycle SHALL decrement the counter and increment pc by 4; stalled cycles SHALL hold both.
REQ-027 The state SHALL return to RUN in the cycle after the counter reaches 1 while not stalled, so flush lasts FLUSH_CYCLES unstalled cycles.
REQ-028 A reserved funct3 on an accepted branch SHALL pulse illegal for one cycle, with no redirect and pc <= pc + 4.
REQ-029 A misaligned taken target SHALL pulse misalign for one cycle, with no redirect and pc <= pc + 4.
REQ-030 taken, illegal and misalign SHALL be registered and mutually exclusive.

Reset
REQ-031 When nReset is low at a rising edge: pc = RESET_PC, state = RUN, counter = 0, and taken, flush, illegal and misalign = 0.
REQ-032 Reset SHALL override stall, branch and jump, including in FLUSH.

Configuration
REQ-033 Macro BRANCH_STATS_EN, when defined, SHALL add two outputs, branch_count[15:0] and taken_count[15:0], as saturating counters of accepted branch/jump events and of redirects, cleared by reset.
REQ-034 Without BRANCH_STATS_EN, those ports and their counters SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-035 The shared package SHALL hold the funct3 encodings (BEQ, BNE, BLT, BGE, BLTU, BGEU), the FSM state enum and the flag index constants.
REQ-036 The design SHALL contain one combinational sub-module, branch_decide (funct3, flags -> take, reserved); the PC, FSM and counters SHALL remain in pc_branch_ctrl.

Verification
REQ-037 Reset release with RESET_PC = 0, no branches, 4 cycles -> pc = 0, 4, 8, 12, 16; flush stays 0.
REQ-038 beq with flags = 2'b01, branch_pc = 0x100, imm = 0x20 -> next pc = 0x120; taken pulses 1 cycle; flush high 2 cycles; then pc = 0x124, 0x128.
REQ-039 bne with flags = 2'b01 -> not taken; pc increments by 4; taken = 0 and flush = 0.
REQ-040 Taken bge with stall held 3 cycles during FLUSH -> pc and flush held; flush totals 2 unstalled cycles; a branch presented during FLUSH is ignored.
REQ-041 funct3 = 010 -> illegal pulses once, no redirect; jump_target = 0x202 -> misalign pulses once, pc += 4.
REQ-042 nReset low during FLUSH -> next cycle pc = RESET_PC and flush = 0; with BRANCH_STATS_EN, 70000 taken branches -> taken_count = 0xFFFF.

Source files
------------

// File: rtl/pc_branch_ctrl_pkg.sv
// pc_branch_ctrl_pkg: funct3 encodings, FSM state enum and comparator flag indices
package pc_branch_ctrl_pkg;
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;
  localparam int FLAG_EQ = 0;
  localparam int FLAG_GE = 1;
  typedef enum logic {RUN, FLUSH} state_e;
endpackage

// File: rtl/pc_branch_ctrl_branch_decide.sv
// branch_decide: branch condition decode from funct3 and comparator flags
module branch_decide
  import pc_branch_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] flags,
  output logic       take,
  output logic       reserved
);
  always_comb begin
    reserved = funct3[2:1] == 2'b01;
    take = funct3 == BEQ                      ? flags[FLAG_EQ]  :
           funct3 == BNE                      ? !flags[FLAG_EQ] :
           (funct3 == BLT || funct3 == BLTU)  ? !flags[FLAG_GE] :
           (funct3 == BGE || funct3 == BGEU)  ? flags[FLAG_GE]  : 1'b0;
  end
endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: fetch PC sequencing with branch/jump redirect and post-redirect flush.
// Optional saturating branch statistics under BRANCH_STATS_EN.
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter int             n            = 32,
  parameter logic [n-1:0]   RESET_PC     = '0,
  parameter int             FLUSH_CYCLES = 2
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         stall,
  input  logic         branch,
  input  logic         jump,
  input  logic [2:0]   funct3,
  input  logic [1:0]   flags,
  input  logic [n-1:0] branch_pc,
  input  logic [n-1:0] imm,
  input  logic [n-1:0] jump_target,
  output logic [n-1:0] pc,
  output logic         taken,
  output logic         flush,
  output logic         illegal,
  output logic         misalign
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]  branch_count,
  output logic [15:0]  taken_count
`endif
);
  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [n-1:0] pc_q, pc_d, target;
  logic         taken_q, taken_d, illegal_q, illegal_d, misalign_q, misalign_d;
  logic         cond_take, reserved, accept, req, redirect;
`ifdef BRANCH_STATS_EN
  logic [15:0]  bcnt_q, bcnt_d, tcnt_q, tcnt_d;
`endif

  branch_decide u_decide (.funct3(funct3), .flags(flags), .take(cond_take), .reserved(reserved));

  always_comb begin
    accept     = state_q == RUN && !stall && (branch || jump);
    target     = jump ? jump_target : branch_pc + imm;
    req        = accept && (jump || cond_take);
    misalign_d = req && target[1:0] != 2'b00;
    redirect   = req && !misalign_d;
    taken_d    = redirect;
    illegal_d  = accept && !jump && reserved;
    pc_d       = redirect ? target : stall ? pc_q : pc_q + n'(4);
    state_d    = redirect ? FLUSH :
                 (state_q == FLUSH && !stall && cnt_q == 3'd1) ? RUN : state_q;
    cnt_d      = redirect ? 3'(FLUSH_CYCLES) :
                 (state_q == FLUSH && !stall) ? cnt_q - 3'd1 : cnt_q;
`ifdef BRANCH_STATS_EN
    bcnt_d     = (accept && bcnt_q != 16'hFFFF) ? bcnt_q + 16'd1 : bcnt_q;
    tcnt_d     = (redirect && tcnt_q != 16'hFFFF) ? tcnt_q + 16'd1 : tcnt_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
`ifdef BRANCH_STATS_EN
      bcnt_q     <= '0;
      tcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      taken_q    <= taken_d;
      illegal_q  <= illegal_d;
      misalign_q <= misalign_d;
`ifdef BRANCH_STATS_EN
      bcnt_q     <= bcnt_d;
      tcnt_q     <= tcnt_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign taken    = taken_q;
  assign flush    = state_q == FLUSH;
  assign illegal  = illegal_q;
  assign misalign = misalign_q;
`ifdef BRANCH_STATS_EN
  assign branch_count = bcnt_q;
  assign taken_count  = tcnt_q;
`endif
endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb_pc_branch_ctrl: directed vector table plus stats saturation sequence (BRANCH_STATS_EN)
module tb_pc_branch_ctrl;
  logic        clock = 1'b0;
  logic        nReset, stall, branch, jump;
  logic [2:0]  funct3;
  logic [1:0]  flags;
  logic [31:0] branch_pc, imm, jump_target, pc;
  logic        taken, flush, illegal, misalign;
`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count, taken_count;
`endif
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  pc_branch_ctrl #(.n(32), .RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
    .clock(clock), .nReset(nReset), .stall(stall), .branch(branch), .jump(jump),
    .funct3(funct3), .flags(flags), .branch_pc(branch_pc), .imm(imm),
    .jump_target(jump_target), .pc(pc), .taken(taken), .flush(flush),
    .illegal(illegal), .misalign(misalign)
`ifdef BRANCH_STATS_EN
    , .branch_count(branch_count), .taken_count(taken_count)
`endif
  );

  typedef struct {
    logic        nrst, stall, br, jp;
    logic [2:0]  f3;
    logic [1:0]  fl;
    logic [31:0] bpc, im, jt, pc;
    logic        tk, fs, il, ma;
  } vec_t;

  vec_t v[31];

  function automatic vec_t mk(logic nrst, logic st, logic br, logic jp, logic [2:0] f3,
                              logic [1:0] fl, logic [31:0] bpc, logic [31:0] im,
                              logic [31:0] jt, logic [31:0] epc, logic tk, logic fs,
                              logic il, logic ma);
    vec_t r;
    r.nrst = nrst; r.stall = st; r.br = br; r.jp = jp; r.f3 = f3; r.fl = fl;
    r.bpc = bpc; r.im = im; r.jt = jt; r.pc = epc; r.tk = tk; r.fs = fs; r.il = il; r.ma = ma;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t x);
    nReset = x.nrst; stall = x.stall; branch = x.br; jump = x.jp; funct3 = x.f3;
    flags = x.fl; branch_pc = x.bpc; imm = x.im; jump_target = x.jt;
  endtask

  initial begin
    // columns: nrst stall br jp f3 flags bpc imm jt | pc taken flush illegal misalign
    v[0]  = mk(0,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h0,   0,0,0,0);
    v[1]  = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h4,   0,0,0,0);
    v[2]  = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h8,   0,0,0,0);
    v[3]  = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'hC,   0,0,0,0);
    v[4]  = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h10,  0,0,0,0);
    v[5]  = mk(1,0,1,0,3'b000,2'b01,32'h100, 32'h20, 32'h0,   32'h120, 1,1,0,0);
    v[6]  = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h124, 0,1,0,0);
    v[7]  = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h128, 0,0,0,0);
    v[8]  = mk(1,0,1,0,3'b001,2'b01,32'h100, 32'h20, 32'h0,   32'h12C, 0,0,0,0);
    v[9]  = mk(1,0,1,0,3'b101,2'b10,32'h200, 32'h40, 32'h0,   32'h240, 1,1,0,0);
    v[10] = mk(1,1,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h240, 0,1,0,0);
    v[11] = mk(1,1,1,0,3'b000,2'b01,32'h100, 32'h20, 32'h0,   32'h240, 0,1,0,0);
    v[12] = mk(1,1,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h240, 0,1,0,0);
    v[13] = mk(1,0,1,0,3'b000,2'b01,32'h100, 32'h20, 32'h0,   32'h244, 0,1,0,0);
    v[14] = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h248, 0,0,0,0);
    v[15] = mk(1,0,1,0,3'b010,2'b11,32'h100, 32'h20, 32'h0,   32'h24C, 0,0,1,0);
    v[16] = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h250, 0,0,0,0);
    v[17] = mk(1,0,0,1,3'b000,2'b00,32'h0,   32'h0,  32'h202, 32'h254, 0,0,0,1);
    v[18] = mk(1,0,0,1,3'b000,2'b00,32'h0,   32'h0,  32'h300, 32'h300, 1,1,0,0);
    v[19] = mk(0,0,0,1,3'b000,2'b00,32'h0,   32'h0,  32'h500, 32'h0,   0,0,0,0);
    v[20] = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h4,   0,0,0,0);
    v[21] = mk(1,0,1,0,3'b100,2'b00,32'h10,  32'hFFFF_FFF8, 32'h0, 32'h8, 1,1,0,0);
    v[22] = mk(1,1,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h8,   0,1,0,0);
    v[23] = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'hC,   0,1,0,0);
    v[24] = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h10,  0,0,0,0);
    v[25] = mk(1,1,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h10,  0,0,0,0);
    v[26] = mk(1,0,1,1,3'b000,2'b01,32'h0,   32'h80, 32'h400, 32'h400, 1,1,0,0);
    v[27] = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h404, 0,1,0,0);
    v[28] = mk(1,0,0,0,3'b000,2'b00,32'h0,   32'h0,  32'h0,   32'h408, 0,0,0,0);
    v[29] = mk(1,1,1,0,3'b000,2'b01,32'h0,   32'h80, 32'h0,   32'h408, 0,0,0,0);
    v[30] = mk(1,0,1,0,3'b111,2'b10,32'h1000,32'h6,  32'h0,   32'h40C, 0,0,0,1);
    @(negedge clock);
    for (int i = 0; i < 31; i++) begin
      apply(v[i]);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d.pc", i), pc, v[i].pc);
      chk($sformatf("v%0d.taken", i), {31'b0, taken}, {31'b0, v[i].tk});
      chk($sformatf("v%0d.flush", i), {31'b0, flush}, {31'b0, v[i].fs});
      chk($sformatf("v%0d.illegal", i), {31'b0, illegal}, {31'b0, v[i].il});
      chk($sformatf("v%0d.misalign", i), {31'b0, misalign}, {31'b0, v[i].ma});
    end
`ifdef BRANCH_STATS_EN
    apply(mk(0,0,0,0,3'b000,2'b00,32'h0,32'h0,32'h0,32'h0,0,0,0,0));
    @(posedge clock); #1;
    chk("stats.branch_reset", {16'b0, branch_count}, 32'h0);
    chk("stats.taken_reset", {16'b0, taken_count}, 32'h0);
    nReset = 1'b1; jump = 1'b1; jump_target = 32'h100;
    for (int i = 0; i < 70000 * 3; i++) @(posedge clock);
    #1;
    chk("stats.branch_sat", {16'b0, branch_count}, 32'hFFFF);
    chk("stats.taken_sat", {16'b0, taken_count}, 32'hFFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
